// File: rtl/mult_seq_pkg.sv
// Package: mult_seq_pkg
// Shared definitions for the multiplier operand sequencer:
//   state_e          FSM state encoding (IDLE=0, RUN=1, HOLD=2)
//   default_timeout  default number of RUN cycles allowed before declaring a hung multiplier
//   entry_width      width of one {a,b} operand pair held in the FIFO
package mult_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } state_e;

  function automatic int unsigned default_timeout(input int unsigned n);
    return 2 * n + 4;
  endfunction

  function automatic int unsigned entry_width(input int unsigned n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/mult_op_sequencer_if.sv
// Interface: mult_op_sequencer_if
// Bundles the operand stream, the multiplier start/finish handshake and the result stream.
//   in_valid/in_ready/in_a/in_b        operand pair stream into the sequencer
//   mul_a/mul_b/mul_start              operands and start level to the multiplier
//   mul_finish/mul_out                 finish flag and 2N-bit product from the multiplier
//   res_valid/res_ready/res_data       product stream out of the sequencer
//   busy/err                           status: activity and sticky timeout
// slave:  the sequencer's view.  master: the surrounding environment's view.
interface mult_op_sequencer_if #(
  parameter int unsigned N = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_a;
  logic [N-1:0]     in_b;
  logic [N-1:0]     mul_a;
  logic [N-1:0]     mul_b;
  logic             mul_start;
  logic             mul_finish;
  logic [2*N-1:0]   mul_out;
  logic             res_valid;
  logic             res_ready;
  logic [2*N-1:0]   res_data;
  logic             busy;
  logic             err;

  modport slave (
    input  in_valid, in_a, in_b, mul_finish, mul_out, res_ready,
    output in_ready, mul_a, mul_b, mul_start, res_valid, res_data, busy, err
  );

  modport master (
    output in_valid, in_a, in_b, mul_finish, mul_out, res_ready,
    input  in_ready, mul_a, mul_b, mul_start, res_valid, res_data, busy, err
  );
endinterface

// File: rtl/sync_fifo.sv
// Module: sync_fifo
// Single-clock FIFO with first-word-fall-through read data.
//   clk, rst_n   clock and asynchronous active-low reset
//   i_push       write i_wdata (ignored while full)
//   i_pop        drop the head entry (ignored while empty)
//   o_rdata      current head entry
//   o_full/o_empty/o_count  occupancy status
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] CountFull = (PtrW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [PtrW:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CountFull);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/mult_op_sequencer.sv
// Module: mult_op_sequencer
// Queues operand pairs and runs a sequential multiplier one pair at a time, returning each
// product in arrival order and flagging a multiplier that never finishes.
//   clk, rst_n   clock and asynchronous active-low reset
//   bus          mult_op_sequencer_if slave: operand stream, multiplier handshake,
//                result stream, busy and sticky err status
module mult_op_sequencer
  import mult_seq_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = default_timeout(N)
) (
  input logic                 clk,
  input logic                 rst_n,
  mult_op_sequencer_if.slave  bus
);
  localparam int unsigned EntryW = entry_width(N);
  localparam int unsigned CntW   = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] WaitLast = CntW'(TIMEOUT - 1);

  state_e             r_state;
  state_e             w_state_d;
  logic [CntW-1:0]    r_wait;
  logic [CntW-1:0]    w_wait_d;
  logic [N-1:0]       r_mul_a;
  logic [N-1:0]       r_mul_b;
  logic [2*N-1:0]     r_res_data;
  logic               r_err;

  logic               w_pop;
  logic               w_capture;
  logic               w_timeout;
  logic [EntryW-1:0]  w_head;
  logic               w_full;
  logic               w_empty;
  logic [$clog2(DEPTH):0] w_count;

  sync_fifo #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (bus.in_valid),
    .i_pop   (w_pop),
    .i_wdata ({bus.in_a, bus.in_b}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_state_d = r_state;
    w_wait_d  = r_wait;
    w_pop     = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_wait_d  = '0;
          w_state_d = StRun;
        end
      end
      StRun: begin
        // r_wait is zero only in the first RUN cycle, so a stale finish is masked there.
        if (r_wait != '0 && bus.mul_finish) begin
          w_capture = 1'b1;
          w_state_d = StHold;
        end else if (r_wait == WaitLast) begin
          w_timeout = 1'b1;
          w_state_d = StHold;
        end else begin
          w_wait_d = r_wait + 1'b1;
        end
      end
      StHold: begin
        if (bus.res_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_wait     <= '0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_res_data <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_wait  <= w_wait_d;
      if (w_pop) begin
        r_mul_a <= w_head[EntryW-1:N];
        r_mul_b <= w_head[N-1:0];
      end
      if (w_capture) begin
        r_res_data <= bus.mul_out;
      end else if (w_timeout) begin
        r_res_data <= '0;
      end
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign bus.in_ready  = !w_full;
  assign bus.mul_a     = r_mul_a;
  assign bus.mul_b     = r_mul_b;
  assign bus.mul_start = (r_state == StRun);
  assign bus.res_valid = (r_state == StHold);
  assign bus.res_data  = r_res_data;
  assign bus.busy      = (r_state != StIdle) || (w_count != '0);
  assign bus.err       = r_err;

endmodule
